// File: rtl/serial_word_receiver_if.sv
// Bus bundle between the serial data pins and the banked display-buffer write port.
// The master side drives DAI/DEN; the slave side (the receiver) drives the RAM write signals.
interface serial_word_receiver_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned BANKS  = 2
);
  logic              DAI;
  logic              DEN;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [BANKS-1:0]  wen;
  logic              bank_done;
  logic              frame_err;

  modport master (
    output DAI, DEN,
    input  addr, data, wen, bank_done, frame_err
  );

  modport slave (
    input  DAI, DEN,
    output addr, data, wen, bank_done, frame_err
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver feeding BANKS display buffers through an active-low write strobe.
// Define SWR_PARITY_EN to append an even-parity bit to every frame and drop frames that fail it.
module serial_word_receiver #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BANKS     = 2,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                   DCK,
  input  logic                   rst,
  serial_word_receiver_if.slave  bus
);

`ifdef SWR_PARITY_EN
  localparam int unsigned FRAME_LEN = DATA_W + 1;
`else
  localparam int unsigned FRAME_LEN = DATA_W;
`endif
  localparam int unsigned BANK_W = $clog2(BANKS);
  localparam int unsigned PTR_W  = ADDR_W + BANK_W;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [BANKS-1:0]     wen_q, wen_d;
  logic                 bank_done_q, bank_done_d;
  logic                 frame_err_q, frame_err_d;

  logic [DATA_W-1:0]    payload;
  logic                 parity_ok;
  logic                 frame_ok;
  logic [BANK_W-1:0]    bank_sel;

  function automatic logic [FRAME_LEN-1:0] shift_in(input logic [FRAME_LEN-1:0] cur,
                                                    input logic                 din);
    if (LSB_FIRST != 0)
      shift_in = {din, cur[FRAME_LEN-1:1]};
    else
      shift_in = {cur[FRAME_LEN-2:0], din};
  endfunction

  // The parity bit is always the last one shifted, so it sits at the far end from the first bit.
  always_comb begin
    payload   = '0;
    parity_ok = 1'b1;
`ifdef SWR_PARITY_EN
    if (LSB_FIRST != 0) begin
      payload   = sr_q[DATA_W-1:0];
      parity_ok = (^sr_q[DATA_W-1:0]) == sr_q[FRAME_LEN-1];
    end else begin
      payload   = sr_q[FRAME_LEN-1:1];
      parity_ok = (^sr_q[FRAME_LEN-1:1]) == sr_q[0];
    end
`else
    payload = sr_q;
`endif
  end

  assign frame_ok = (cnt_q == CNT_FULL) && parity_ok;
  assign bank_sel = ptr_q[PTR_W-1 -: BANK_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wen_d       = '1;
    bank_done_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.DEN) begin
          sr_d    = shift_in('0, bus.DAI);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.DEN) begin
          sr_d = shift_in(sr_q, bus.DAI);
          if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
        end else if (frame_ok) begin
          // Write strobe and word are registered here so they line up with the COMMIT cycle.
          state_d     = COMMIT;
          wen_d       = ~(BANKS'(1) << bank_sel);
          addr_d      = ptr_q[ADDR_W-1:0];
          data_d      = payload;
          bank_done_d = &ptr_q[ADDR_W-1:0];
          cnt_d       = '0;
        end else begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end
      end

      COMMIT: begin
        ptr_d = ptr_q + PTR_W'(1);
        if (bus.DEN) begin
          sr_d    = shift_in('0, bus.DAI);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge DCK or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wen_q       <= '1;
      bank_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wen_q       <= wen_d;
      bank_done_q <= bank_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.wen       = wen_q;
  assign bus.bank_done = bank_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: one LSB-first and one MSB-first instance share the serial link.
// Define SWR_PARITY_EN to append parity bits to frames and exercise the parity-drop path.
module tb_serial_word_receiver;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned BANKS  = 2;
  localparam int unsigned WORDS  = BANKS << ADDR_W;
`ifdef SWR_PARITY_EN
  localparam int FL = DATA_W + 1;
`else
  localparam int FL = DATA_W;
`endif

  typedef struct {
    logic [BANKS-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bank_done;
    logic              frame_err;
  } exp_t;

  logic DCK = 1'b0;
  logic rst = 1'b1;
  always #5 DCK = ~DCK;

  serial_word_receiver_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS)) bus_lsb ();
  serial_word_receiver_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS)) bus_msb ();

  assign bus_msb.DAI = bus_lsb.DAI;
  assign bus_msb.DEN = bus_lsb.DEN;

  serial_word_receiver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .LSB_FIRST(1)) dut_lsb (
    .DCK (DCK),
    .rst (rst),
    .bus (bus_lsb.slave)
  );

  serial_word_receiver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .LSB_FIRST(0)) dut_msb (
    .DCK (DCK),
    .rst (rst),
    .bus (bus_msb.slave)
  );

  exp_t q_lsb[$];
  exp_t q_msb[$];
  int   total = 0;
  int   bad   = 0;
  int   ptr_model = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W; i++)
      bitrev[DATA_W-1-i] = v[i];
  endfunction

  task automatic compare_event(input string tag, input exp_t e, input logic [BANKS-1:0] wen,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                               input logic bank_done, input logic frame_err);
    check({tag, "_wen"}, 32'(wen), 32'(e.wen));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(e.frame_err));
    check({tag, "_bank_done"}, 32'(bank_done), 32'(e.bank_done));
    if (e.frame_err == 1'b0) begin
      check({tag, "_addr"}, 32'(addr), 32'(e.addr));
      check({tag, "_data"}, 32'(data), 32'(e.data));
    end
  endtask

  // Each monitor consumes one expected event whenever its DUT shows a write strobe or frame error.
  always @(negedge DCK) begin
    if (!rst && (bus_lsb.wen !== '1 || bus_lsb.frame_err !== 1'b0 || bus_lsb.bank_done !== 1'b0)) begin
      if (q_lsb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL lsb_unexpected: got wen=%b frame_err=%b want no event", bus_lsb.wen, bus_lsb.frame_err);
      end else begin
        compare_event("lsb", q_lsb.pop_front(), bus_lsb.wen, bus_lsb.addr, bus_lsb.data,
                      bus_lsb.bank_done, bus_lsb.frame_err);
      end
    end
  end

  always @(negedge DCK) begin
    if (!rst && (bus_msb.wen !== '1 || bus_msb.frame_err !== 1'b0 || bus_msb.bank_done !== 1'b0)) begin
      if (q_msb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL msb_unexpected: got wen=%b frame_err=%b want no event", bus_msb.wen, bus_msb.frame_err);
      end else begin
        compare_event("msb", q_msb.pop_front(), bus_msb.wen, bus_msb.addr, bus_msb.data,
                      bus_msb.bank_done, bus_msb.frame_err);
      end
    end
  end

  task automatic push_write(input logic [DATA_W-1:0] value);
    exp_t e;
    int   bank;
    int   addr;
    bank        = ptr_model / (1 << ADDR_W);
    addr        = ptr_model % (1 << ADDR_W);
    e.wen       = ~(BANKS'(1) << bank);
    e.addr      = ADDR_W'(addr);
    e.data      = value;
    e.bank_done = (addr == (1 << ADDR_W) - 1);
    e.frame_err = 1'b0;
    q_lsb.push_back(e);
    e.data      = bitrev(value);
    q_msb.push_back(e);
    ptr_model   = (ptr_model + 1) % WORDS;
  endtask

  task automatic push_err();
    exp_t e;
    e.wen       = '1;
    e.addr      = '0;
    e.data      = '0;
    e.bank_done = 1'b0;
    e.frame_err = 1'b1;
    q_lsb.push_back(e);
    q_msb.push_back(e);
  endtask

  // Bits go out value[0] first; anything past the payload is the supplied parity bit.
  task automatic send_frame(input logic [DATA_W-1:0] value, input int nbits, input logic par);
    for (int k = 0; k < nbits; k++) begin
      @(negedge DCK);
      bus_lsb.DEN = 1'b1;
      bus_lsb.DAI = (k < DATA_W) ? value[k] : par;
    end
    @(negedge DCK);
    bus_lsb.DEN = 1'b0;
    bus_lsb.DAI = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [DATA_W-1:0] value);
    push_write(value);
    send_frame(value, FL, ^value);
  endtask

  task automatic check_output(input string tag);
    check({tag, "_lsb_wen"},       32'(bus_lsb.wen),       32'h3);
    check({tag, "_lsb_addr"},      32'(bus_lsb.addr),      32'h0);
    check({tag, "_lsb_data"},      32'(bus_lsb.data),      32'h0);
    check({tag, "_lsb_bank_done"}, 32'(bus_lsb.bank_done), 32'h0);
    check({tag, "_lsb_frame_err"}, 32'(bus_lsb.frame_err), 32'h0);
    check({tag, "_msb_wen"},       32'(bus_msb.wen),       32'h3);
    check({tag, "_msb_data"},      32'(bus_msb.data),      32'h0);
  endtask

  initial begin
    bus_lsb.DEN = 1'b0;
    bus_lsb.DAI = 1'b0;
    repeat (3) @(negedge DCK);
    check_output("reset");
    rst = 1'b0;

    $display("[TB] dropped frames: short, overlong, single bit");
    push_err();
    send_frame(16'h7FFF, FL - 1, 1'b0);
    push_err();
    send_frame(16'hFFFF, FL + 1, 1'b1);
    push_err();
    send_frame(16'h0001, 1, 1'b0);

    $display("[TB] basic words");
    apply_stimulus(16'hA5C3);
    apply_stimulus(16'h1234);

    $display("[TB] back-to-back run through both banks and wrap");
    for (int i = 0; i < WORDS; i++)
      apply_stimulus(DATA_W'(i * 7 + 16'h0101));

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 8; k++) begin
      @(negedge DCK);
      bus_lsb.DEN = 1'b1;
      bus_lsb.DAI = k[0];
    end
    @(negedge DCK);
    rst = 1'b1;
    bus_lsb.DEN = 1'b0;
    bus_lsb.DAI = 1'b0;
    @(negedge DCK);
    check_output("rst_frame");
    rst = 1'b0;
    ptr_model = 0;
    apply_stimulus(16'hBEEF);

    $display("[TB] reset mid-commit");
    send_frame(16'h3C3C, FL, ^16'h3C3C);
    @(posedge DCK);
    #1 rst = 1'b1;
    @(negedge DCK);
    check_output("rst_commit");
    rst = 1'b0;
    ptr_model = 0;
    apply_stimulus(16'h5A5A);

`ifdef SWR_PARITY_EN
    $display("[TB] parity check");
    push_write(16'h0001);
    send_frame(16'h0001, FL, 1'b1);
    push_err();
    send_frame(16'h0001, FL, 1'b0);
`endif

    repeat (6) @(negedge DCK);
    check("lsb_pending", 32'(q_lsb.size()), 32'h0);
    check("msb_pending", 32'(q_msb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Parametrised serial-to-parallel word receiver for the LED display controller input path. Shifts bits in from the DAI/DEN serial link, checks frame length (and optionally parity), and writes each valid word to one of BANKS display buffers through a one-cycle active-low write strobe. Sits between the external data pins and the banked frame-buffer RAMs. Generalises the fixed 16-bit, two-bank receiver with configurable width, depth, bank count and bit order, plus frame-error detection.

## Interface
- DATA_W, 16: payload bits per word.
- ADDR_W, 9: RAM address width per bank; a bank holds 2^ADDR_W words.
- BANKS, 2: number of buffer banks; power of two, ≥2.
- LSB_FIRST, 1: 1 = first serial bit lands in data[0]; 0 = first bit lands in data[DATA_W-1].

- DCK  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- DAI  input  1  serial data bit, sampled while DEN=1.
- DEN  input  1  frame enable; high for exactly one frame's bits.
- addr  output  ADDR_W  write address within selected bank.
- data  output  DATA_W  assembled word.
- wen  output  BANKS  active-low write enables, at most one low.
- bank_done  output  1  one-cycle pulse on the write of a bank's last address.
- frame_err  output  1  one-cycle pulse when a frame is dropped.

## Operation
- Internal: state (IDLE, SHIFT, COMMIT), bit counter saturating at FRAME_LEN+1, shift register of FRAME_LEN bits, word pointer of ADDR_W+log2(BANKS) bits. FRAME_LEN = DATA_W (DATA_W+1 with parity).
- IDLE: DEN=1 → sample DAI as bit 1, cnt=1, go SHIFT. DEN=0 → stay.
- SHIFT: DEN=1 → shift in DAI, cnt++ (saturating). DEN=0 → DAI ignored; if cnt==FRAME_LEN (and parity ok) go COMMIT; else pulse frame_err next cycle, go IDLE, pointer unchanged.
- COMMIT (one cycle): wen[ptr bank bits] = 0, others 1; addr = ptr low ADDR_W bits; data = payload; bank_done=1 if addr is all ones. Pointer increments at end of COMMIT. DEN=1 in COMMIT → starts next frame (bit 1 sampled, go SHIFT); DEN=0 → IDLE.
- Bit order: LSB_FIRST=1 shifts right with new bit at MSB; LSB_FIRST=0 shifts left with new bit at LSB.
- Pointer wraps from BANKS·2^ADDR_W−1 to 0; bank order 0,1,…,BANKS−1,0.
- data holds its value outside SHIFT cycles; only valid during wen-low cycle.

## Timing
- Last bit sampled at edge E−1, DEN=0 sampled at edge E; wen low from E to E+1 (RAM writes at E+1). Latency: one cycle after DEN falls.
- frame_err high from E to E+1 on dropped frames; wen stays all ones.
- Minimum frame gap: one DCK cycle of DEN=0.
- Reset values: state IDLE, cnt 0, shift register 0, pointer 0, addr 0, data 0, wen all ones, bank_done 0, frame_err 0.
- Reset mid-frame or mid-COMMIT: frame discarded, no write completes, pointer 0.
- Overlong frames (cnt saturated) and single-bit frames both drop with frame_err.

## Configuration
- SWR_PARITY_EN defined: FRAME_LEN = DATA_W+1; final serial bit is even parity over the DATA_W payload bits; mismatch drops the frame with frame_err. Parity bit never reaches data.
- SWR_PARITY_EN undefined: FRAME_LEN = DATA_W, no parity logic.

## Test plan
- Defaults, no parity: 16 bits of 16'hA5C3 LSB first → wen=2'b10, addr=0, data=16'hA5C3 for one cycle the cycle after DEN falls; next word goes to addr=1.
- LSB_FIRST=0: same bit stream 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 → data=16'hC3A5.
- 15-bit frame then 17-bit frame → two frame_err pulses, wen stays 2'b11, next valid word written at addr=0.
- 512 words back-to-back (one-cycle gaps) → word 511 has wen=2'b10, addr=511, bank_done=1; word 512 has wen=2'b01, addr=0; word 1024 wraps to wen=2'b10, addr=0.
- Assert rst after 8 bits of a frame → all outputs at reset values, no wen pulse; next full frame writes addr=0.
- SWR_PARITY_EN: 16'h0001 with parity bit 1 → written; with parity bit 0 → frame_err, no write.
